mod_split_case_dec: RTL and testbench

- Receive-side decoder for the split-case encoding. Each input beat carries a selector and the two encoded bytes (case_a, case_b).
- The block recovers the original data byte and checks that case_b is consistent with case_a.
- Decoded beats are buffered in a small FIFO and delivered over a valid/ready handshake.
- Sits downstream of the split-case encoder and keeps running error statistics.

---
 rtl/mod_split_case_dec.sv | 122 ++++++++++++
 tb/tb_mod_split_case_dec.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mod_split_case_dec.sv
// Receive-side split-case decoder: recovers the data byte, flags case_b mismatches,
// buffers decoded beats in a small FIFO and keeps saturating error statistics.
module mod_split_case_dec #(
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [7:0]       in_case_a,
    input  logic [7:0]       in_case_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [1:0]       out_sel,
    output logic             out_err,
    input  logic             clr_err,
    output logic [ERR_W-1:0] err_count,
    output logic             err_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]       r_memData [DEPTH];
    logic [1:0]       r_memSel  [DEPTH];
    logic             r_memErr  [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic [ERR_W-1:0] r_errCount;
    logic             r_errSticky;

    logic [7:0]       w_data;
    logic [7:0]       w_expB;
    logic             w_err;
    logic             w_push;
    logic             w_pop;

    // Decode happens at the input so each FIFO entry already holds the final result.
    always_comb begin
        w_data = in_case_a;
        w_expB = in_case_a;
        case (in_sel)
            2'b00: begin
                w_data = in_case_a - 8'd5;
                w_expB = in_case_a + 8'd1;
            end
            2'b01: begin
                w_data = in_case_a + 8'd5;
                w_expB = in_case_a - 8'd1;
            end
            default: begin
                w_data = in_case_a;
                w_expB = in_case_a;
            end
        endcase
    end

    assign w_err     = (in_case_b != w_expB);
    assign in_ready  = !rst && (r_count < DEPTH_C);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_data   = r_memData[r_rdPtr];
    assign out_sel    = r_memSel[r_rdPtr];
    assign out_err    = r_memErr[r_rdPtr];
    assign err_count  = r_errCount;
    assign err_sticky = r_errSticky;

    // Storage is reset too, so the head reads back as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_memData[i] <= 8'd0;
                r_memSel[i]  <= 2'd0;
                r_memErr[i]  <= 1'b0;
            end
        end else if (w_push) begin
            r_memData[r_wrPtr] <= w_data;
            r_memSel[r_wrPtr]  <= in_sel;
            r_memErr[r_wrPtr]  <= w_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A clear coinciding with an errored accept lands as "cleared, then counted once".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errCount  <= '0;
            r_errSticky <= 1'b0;
        end else if (w_push && w_err) begin
            r_errSticky <= 1'b1;
            if (clr_err)
                r_errCount <= ERR_W'(1);
            else if (r_errCount != '1)
                r_errCount <= r_errCount + 1'b1;
        end else if (clr_err) begin
            r_errCount  <= '0;
            r_errSticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_split_case_dec.sv
// Directed self-checking bench for mod_split_case_dec with hand-computed expectations.
module tb_mod_split_case_dec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_sel = 2'd0;
    logic [7:0] in_case_a = 8'd0;
    logic [7:0] in_case_b = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] out_sel;
    logic       out_err;
    logic       clr_err = 1'b0;
    logic [7:0] err_count;
    logic       err_sticky;

    int passCount  = 0;
    int totalCount = 0;

    mod_split_case_dec #(.DEPTH(2), .ERR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_case_a  (in_case_a),
        .in_case_b  (in_case_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_err    (out_err),
        .clr_err    (clr_err),
        .err_count  (err_count),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs changed 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
        in_valid  = v;
        in_sel    = s;
        in_case_a = a;
        in_case_b = b;
    endtask

    task automatic test_reset();
        #2;
        totalCount++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); else passCount++;
        totalCount++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passCount++;
        totalCount++; if ({out_data, out_sel, out_err} !== 11'd0) $display("[TB] FAIL reset_out_fields got %h/%h/%b want 0", out_data, out_sel, out_err); else passCount++;
        totalCount++; if ({err_count, err_sticky} !== 9'd0) $display("[TB] FAIL reset_stats got %0d/%b want 0/0", err_count, err_sticky); else passCount++;
        tick();
        rst = 1'b0;
        #1;
        totalCount++; if (in_ready !== 1'b1) $display("[TB] FAIL release_in_ready got %b want 1", in_ready); else passCount++;
    endtask

    task automatic test_basic();
        logic [1:0] sels [3] = '{2'b00, 2'b01, 2'b11};
        logic [7:0] as   [3] = '{8'h0A, 8'h00, 8'h3C};
        logic [7:0] bs   [3] = '{8'h0B, 8'hFF, 8'h3C};
        logic [7:0] exps [3] = '{8'h05, 8'h05, 8'h3C};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sels[i], as[i], bs[i]);
            tick();
            totalCount++;
            if (out_valid !== 1'b1 || out_data !== exps[i] || out_sel !== sels[i] || out_err !== 1'b0)
                $display("[TB] FAIL basic_beat%0d got v=%b d=%h s=%h e=%b want v=1 d=%h s=%h e=0",
                         i, out_valid, out_data, out_sel, out_err, exps[i], sels[i]);
            else passCount++;
        end
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        tick();
        totalCount++; if (out_valid !== 1'b0) $display("[TB] FAIL basic_drained got %b want 0", out_valid); else passCount++;
        totalCount++; if (err_count !== 8'd0) $display("[TB] FAIL basic_err_count got %0d want 0", err_count); else passCount++;
    endtask

    task automatic test_wrap();
        logic [7:0] as   [2] = '{8'h02, 8'hFF};
        logic [7:0] bs   [2] = '{8'h03, 8'h00};
        logic [7:0] exps [2] = '{8'hFD, 8'hFA};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b00, as[i], bs[i]);
            tick();
            totalCount++;
            if (out_valid !== 1'b1 || out_data !== exps[i] || out_err !== 1'b0)
                $display("[TB] FAIL wrap_beat%0d got v=%b d=%h e=%b want v=1 d=%h e=0", i, out_valid, out_data, out_err, exps[i]);
            else passCount++;
        end
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        tick();
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b10, 8'h21 + 8'(i), 8'h21 + 8'(i));
            if (in_ready) accepted++;
            tick();
            totalCount++;
            if (out_valid !== 1'b1 || out_data !== 8'h21)
                $display("[TB] FAIL bp_stable%0d got v=%b d=%h want v=1 d=21", i, out_valid, out_data);
            else passCount++;
        end
        totalCount++; if (accepted !== 2) $display("[TB] FAIL bp_accepted got %0d want 2", accepted); else passCount++;
        totalCount++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_full_in_ready got %b want 0", in_ready); else passCount++;
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        out_ready = 1'b1;
        tick();
        totalCount++; if (out_valid !== 1'b1 || out_data !== 8'h22) $display("[TB] FAIL bp_second got v=%b d=%h want v=1 d=22", out_valid, out_data); else passCount++;
        totalCount++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_after_pop got %b want 1", in_ready); else passCount++;
        tick();
        totalCount++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_drained got %b want 0", out_valid); else passCount++;
    endtask

    task automatic test_errors();
        out_ready = 1'b1;
        drive(1'b1, 2'b10, 8'h11, 8'h12);
        tick();
        totalCount++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 8'h11) $display("[TB] FAIL err_flag got v=%b e=%b d=%h want v=1 e=1 d=11", out_valid, out_err, out_data); else passCount++;
        totalCount++; if (err_count !== 8'd1 || err_sticky !== 1'b1) $display("[TB] FAIL err_first got %0d/%b want 1/1", err_count, err_sticky); else passCount++;
        for (int i = 0; i < 254; i++) tick();
        totalCount++; if (err_count !== 8'd255) $display("[TB] FAIL err_reach_max got %0d want 255", err_count); else passCount++;
        for (int i = 0; i < 46; i++) tick();
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        totalCount++; if (err_count !== 8'd255 || err_sticky !== 1'b1) $display("[TB] FAIL err_saturate got %0d/%b want 255/1", err_count, err_sticky); else passCount++;
        tick();
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        clr_err = 1'b1;
        drive(1'b1, 2'b00, 8'h40, 8'h40);
        tick();
        totalCount++; if (err_count !== 8'd1 || err_sticky !== 1'b1) $display("[TB] FAIL clr_with_err got %0d/%b want 1/1", err_count, err_sticky); else passCount++;
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        tick();
        totalCount++; if (err_count !== 8'd0 || err_sticky !== 1'b0) $display("[TB] FAIL clr_alone got %0d/%b want 0/0", err_count, err_sticky); else passCount++;
        clr_err = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 8'h50, 8'h50);
        tick();
        drive(1'b1, 2'b10, 8'h60, 8'h60);
        tick();
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        totalCount++; if (out_valid !== 1'b1 || err_count !== 8'd1) $display("[TB] FAIL mid_pre got v=%b c=%0d want v=1 c=1", out_valid, err_count); else passCount++;
        #2;
        rst = 1'b1;
        #1;
        totalCount++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_async_valid got %b want 0", out_valid); else passCount++;
        totalCount++; if (err_count !== 8'd0 || err_sticky !== 1'b0) $display("[TB] FAIL mid_async_stats got %0d/%b want 0/0", err_count, err_sticky); else passCount++;
        tick();
        rst = 1'b0;
        #1;
        totalCount++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL mid_release got r=%b v=%b want r=1 v=0", in_ready, out_valid); else passCount++;
        out_ready = 1'b1;
        drive(1'b1, 2'b01, 8'h10, 8'h0F);
        tick();
        drive(1'b0, 2'd0, 8'd0, 8'd0);
        totalCount++; if (out_valid !== 1'b1 || out_data !== 8'h15 || out_err !== 1'b0) $display("[TB] FAIL mid_next_beat got v=%b d=%h e=%b want v=1 d=15 e=0", out_valid, out_data, out_err); else passCount++;
        tick();
    endtask

    initial begin
        $display("[TB] starting mod_split_case_dec bench");
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_errors();
        test_clr();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
